// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin owner selection for the shared 8-input mux8 datapath.
// Exactly one requester owns the bus at a time; the owner index drives the mux8
// select directly, so the owner's data is on the bus in the same cycle as its grant.
module bus_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned PARK_SEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [3:0] select,
    output logic       bus_valid
);

    // A lone owner's hold counter still needs somewhere to saturate, so MAX_HOLD=0
    // keeps a 1-bit counter that parks at 1.
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HCNT_SAT = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);
    localparam logic [3:0]    PARK     = {1'b0, 3'(PARK_SEL)};

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t        state;
    logic [2:0]    owner;
    logic [2:0]    ptr;
    logic [HW-1:0] hcnt;

    logic [3:0]    idle_pick;
    logic [3:0]    hand_pick;
    logic [7:0]    other_req;
    logic          preempt;

    // First set bit of r at or after start, wrapping 7->0.
    // Result is {found, index}; the downward loop lets the nearest offset win.
    function automatic logic [3:0] scan_from(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Candidate winners: a fresh pick from the rotation pointer when idle, and the
    // next requester after the current owner (owner masked) for release or preemption.
    always_comb begin
        other_req = req & ~(8'b0000_0001 << owner);
        idle_pick = scan_from(req, ptr);
        hand_pick = scan_from(other_req, owner + 3'd1);
        preempt   = (MAX_HOLD != 0) && (hcnt == HCNT_SAT) && hand_pick[3];
    end

    // Ownership state machine with registered grant/select/valid outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 3'd0;
            ptr       <= 3'd0;
            hcnt      <= '0;
            grant     <= 8'h00;
            select    <= PARK;
            bus_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_pick[3]) begin
                        state     <= OWNED;
                        owner     <= idle_pick[2:0];
                        ptr       <= idle_pick[2:0] + 3'd1;
                        hcnt      <= HW'(1);
                        grant     <= 8'b0000_0001 << idle_pick[2:0];
                        select    <= {1'b0, idle_pick[2:0]};
                        bus_valid <= 1'b1;
                    end
                end
                OWNED: begin
                    if (!req[owner] || preempt) begin
                        if (hand_pick[3]) begin
                            owner     <= hand_pick[2:0];
                            ptr       <= hand_pick[2:0] + 3'd1;
                            hcnt      <= HW'(1);
                            grant     <= 8'b0000_0001 << hand_pick[2:0];
                            select    <= {1'b0, hand_pick[2:0]};
                            bus_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            hcnt      <= '0;
                            grant     <= 8'h00;
                            select    <= PARK;
                            bus_valid <= 1'b0;
                        end
                    end else if (hcnt != HCNT_SAT) begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= 8'h00;
                    select    <= PARK;
                    bus_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter8.sv
// tb_bus_arbiter8: directed scenarios plus randomized request traffic, each cycle
// compared against a reference model that tracks owner/pointer/hold as plain integers.
module tb_bus_arbiter8;

    localparam int MAX_HOLD = 4;
    localparam int PARK_SEL = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [3:0] select;
    logic       bus_valid;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner index or -1 when idle.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;

    // mux8 stand-in: input i carries i*8'h11.
    logic [7:0] mux_in [8];
    logic [7:0] mux_out;

    bus_arbiter8 #(
        .MAX_HOLD(MAX_HOLD),
        .PARK_SEL(PARK_SEL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .grant(grant),
        .select(select),
        .bus_valid(bus_valid)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Combinational bus data as seen by a mux8 driven from select.
    always_comb begin
        mux_out = mux_in[select[2:0]];
    end

    function automatic void modelReset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endfunction

    function automatic void modelStep(input logic [7:0] r);
        int nxt;
        int sat;
        logic [7:0] others;
        nxt = -1;
        sat = (MAX_HOLD > 0) ? MAX_HOLD : 1;
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                if (nxt < 0 && r[(m_ptr + k) % 8]) nxt = (m_ptr + k) % 8;
            end
            if (nxt >= 0) begin
                m_owner = nxt;
                m_hold  = 1;
                m_ptr   = (nxt + 1) % 8;
            end
        end else begin
            others = r & ~(8'h01 << m_owner);
            if (!r[m_owner] || (MAX_HOLD > 0 && m_hold >= MAX_HOLD && others != 8'h00)) begin
                for (int k = 1; k < 8; k++) begin
                    if (nxt < 0 && others[(m_owner + k) % 8]) nxt = (m_owner + k) % 8;
                end
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_hold  = 1;
                    m_ptr   = (nxt + 1) % 8;
                end else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (m_hold < sat) begin
                m_hold = m_hold + 1;
            end
        end
    endfunction

    function automatic logic [7:0] expGrant();
        return (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    endfunction

    function automatic logic [3:0] expSelect();
        return (m_owner < 0) ? 4'(PARK_SEL) : 4'(m_owner);
    endfunction

    task automatic applyReset();
        reset = 1'b1;
        @(posedge clk);
        modelReset();
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] r);
        req = r;
        @(posedge clk);
        modelStep(r);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (grant === expGrant()) else begin
            errors++;
            $error("[TB] FAIL %s grant: observed %h expected %h (req %h)", tag, grant, expGrant(), req);
        end
        checks++;
        assert (select === expSelect()) else begin
            errors++;
            $error("[TB] FAIL %s select: observed %0d expected %0d (req %h)", tag, select, expSelect(), req);
        end
        checks++;
        assert (bus_valid === (m_owner >= 0)) else begin
            errors++;
            $error("[TB] FAIL %s bus_valid: observed %b expected %b (req %h)", tag, bus_valid, (m_owner >= 0), req);
        end
    endtask

    initial begin
        logic [7:0] r;
        for (int i = 0; i < 8; i++) mux_in[i] = 8'(i * 8'h11);
        reset = 1'b1;
        req   = 8'h00;

        // Reset state
        applyReset();
        checkOutput("reset");
        checkValue("reset_select", {4'h0, select}, 8'(PARK_SEL));

        // Single request
        applyStimulus(8'h04);
        checkOutput("single_grant");
        checkValue("single_grant_const", grant, 8'h04);
        checkValue("single_mux_out", mux_out, 8'h22);
        applyStimulus(8'h00);
        checkOutput("single_release");
        checkValue("single_release_valid", {7'h0, bus_valid}, 8'h00);

        // Round-robin order with each owner dropping its bit once granted
        applyReset();
        applyStimulus(8'hFF);
        checkValue("rr_first", grant, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(8'hFF & ~(8'h01 << (k - 1)));
            checkOutput("rr_step");
            checkValue("rr_order", grant, 8'h01 << (k % 8));
            checkValue("rr_no_gap", {7'h0, bus_valid}, 8'h01);
        end

        // Preemption under steady contention
        applyReset();
        for (int n = 1; n <= 12; n++) begin
            applyStimulus(8'h03);
            checkOutput("preempt");
            checkValue("preempt_owner", grant, 8'h01 << (((n - 1) / MAX_HOLD) % 2));
        end

        // A lone owner is never preempted; the saturated hold counter shows up as an
        // immediate handoff once a competitor appears.
        applyReset();
        for (int n = 0; n < 20; n++) begin
            applyStimulus(8'h10);
            checkValue("alone_grant", grant, 8'h10);
        end
        checkValue("alone_select", {4'h0, select}, 8'h04);
        applyStimulus(8'h11);
        checkOutput("alone_then_contend");
        checkValue("alone_preempt_now", grant, 8'h01);

        // Reset mid-grant
        applyReset();
        applyStimulus(8'h20);
        applyStimulus(8'h20);
        checkValue("mid_owner5", grant, 8'h20);
        applyReset();
        checkOutput("mid_reset");
        applyStimulus(8'h81);
        checkValue("mid_after_reset", grant, 8'h01);
        applyStimulus(8'h80);
        checkValue("mid_release_to7", grant, 8'h80);
        checkOutput("mid_release");

        // Handoff with the old owner masked
        applyReset();
        applyStimulus(8'h08);
        checkValue("mask_owner3", grant, 8'h08);
        applyStimulus(8'h02);
        checkValue("mask_handoff", grant, 8'h02);
        checkValue("mask_select", {4'h0, select}, 8'h01);

        // Randomized traffic with occasional resets
        applyReset();
        r = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                applyReset();
                checkOutput("rand_reset");
            end else begin
                case ($urandom_range(0, 3))
                    0: r = 8'($urandom);
                    1: r = r;
                    2: r = 8'($urandom) & 8'($urandom);
                    default: r = r ^ (8'h01 << $urandom_range(0, 7));
                endcase
                applyStimulus(r);
                checkOutput("random");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter8.md
# bus_arbiter8

Round-robin arbiter that shares the 8-input, 8-bit `mux8` datapath between up to eight requesters. It accepts per-source request lines and grants exactly one owner at a time. It drives the `mux8` `select` input directly so that the owner's data appears on the shared bus. It sits between the requesting units and the `mux8` instance, and replaces any static select wiring.

## Interface
- `MAX_HOLD`, 4: maximum consecutive cycles an owner keeps the grant while others are waiting. 0 disables preemption.
- `PARK_SEL`, 0: `select` value driven when no grant is active. Range 0–7.
- `clk`  in  1  single system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines; bit i = source i (mux8 `in<i>`).
- `grant`  out  8  one-hot grant, registered; all-zero when idle.
- `select`  out  4  registered binary index of the owner, to mux8 `select`. Bit 3 is always 0.
- `bus_valid`  out  1  registered; 1 when `grant` is non-zero.

## Operation
- Reset behaviour, on any rising edge with `reset`=1:
  - `grant`=0, `select`=PARK_SEL, `bus_valid`=0.
  - State IDLE, rotation pointer `ptr`=0, hold counter `hcnt`=0.
  - Reset overrides all other inputs in that cycle.
- States: IDLE and OWNED (owner index `w`).
- Winner selection:
  - Scan `req` upward from index `ptr`, wrapping 7→0. The first set bit wins.
  - When a winner is picked, `ptr` becomes winner+1 mod 8.
- IDLE:
  - If `req`≠0: go to OWNED with `w`=winner, `grant`=1<<w, `select`=w, `bus_valid`=1, `hcnt`=1.
  - Otherwise stay in IDLE, holding the reset output values.
- OWNED with owner `w`, in priority order:
  1. Release: if `req[w]`=0, pick a winner from `req` with bit w masked, scanning from w+1.
     - If a winner exists, hand off directly to it with `hcnt`=1. There is no idle gap.
     - If no winner exists, go to IDLE: `grant`=0, `select`=PARK_SEL, `bus_valid`=0.
  2. Preempt: if `req[w]`=1, `MAX_HOLD`≠0, `hcnt`=`MAX_HOLD`, and any other `req` bit is set, hand off to the next requester after w, excluding w, with `hcnt`=1.
  3. Hold: otherwise keep `w`. `hcnt` increments and saturates at `MAX_HOLD`. When `MAX_HOLD`=0, `hcnt` saturates at 1.
- `hcnt` width is clog2(MAX_HOLD+1), minimum 1 bit.
- `grant` is always zero or one-hot. `select` always equals the index of the set `grant` bit when `bus_valid`=1.
- A requester whose `req` drops and rises again in the same cycle is not observable, because `req` is sampled only at edges.

## Timing
- Grant latency: a `req` sampled high at edge k produces `grant`/`select`/`bus_valid` valid after edge k.
- Release latency: an owner's `req` sampled low at edge k produces the new owner, or IDLE, after edge k.
- Handoff between owners takes zero dead cycles. `bus_valid` stays 1 across the handoff.
- The mux8 output follows `select` combinationally, so bus data is valid in the same cycle as `grant`.
- Preemption: with continuous contention, an owner holds the grant for exactly `MAX_HOLD` cycles.
- Simultaneous new requests are resolved by the `ptr` scan only. There is no fixed priority.
- Reset mid-operation takes effect at the next edge. The bus returns to PARK_SEL, and the previous owner gets no release cycle.

## Test plan
- **Single request:** after reset, `req`=8'h04 with mux inputs 8'h00…8'h77.
  - Next edge: `grant`=8'h04, `select`=2, `bus_valid`=1, mux out=8'h22.
  - Dropping `req`: next edge `grant`=0, `select`=0, `bus_valid`=0.
- **Round-robin order:** after reset, `req`=8'hFF, and each owner drops its bit for one cycle after being granted.
  - Grant sequence is 0,1,2,…,7,0 with no idle cycle between owners.
- **Preemption:** `MAX_HOLD`=4, `req`=8'h03 held steady.
  - Owner 0 for 4 cycles, then owner 1 for 4 cycles, then owner 0. `bus_valid` is continuously 1.
- **No preemption when alone:** `req`=8'h10 held for 20 cycles.
  - `grant`=8'h10 throughout, `hcnt` saturates at 4, no glitch on `select`.
- **Reset mid-grant:** owner 5 active, assert `reset` for one edge.
  - `grant`=0, `select`=PARK_SEL, `bus_valid`=0.
  - Then `req`=8'h81: next grant goes to 0 (because `ptr`=0), then to 7 on release.
- **Handoff with masking:** owner 3, `req` goes 8'h08→8'h02 in one cycle.
  - Next edge: `grant`=8'h02, `select`=1. The scan wraps from 4 and owner 3 is never re-granted.
